// File: rtl/anabellek_hakem_n.sv
// N-channel round-robin arbiter funnelling requesters onto a single iomem port.
// Optional iomem_ready watchdog enabled by defining ANABELLEK_ZAMANASIMI_EN.
module anabellek_hakem_n #(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_CH-1:0]            ch_valid_i,
    input  logic [NUM_CH*DATA_W/8-1:0]   ch_wstrb_i,
    input  logic [NUM_CH*ADDR_W-1:0]     ch_addr_i,
    input  logic [NUM_CH*DATA_W-1:0]     ch_wdata_i,
    output logic [NUM_CH-1:0]            ch_ready_o,
    output logic [DATA_W-1:0]            ch_rdata_o,
    output logic                         iomem_valid,
    input  logic                         iomem_ready,
    output logic [DATA_W/8-1:0]          iomem_wstrb,
    output logic [ADDR_W-1:0]            iomem_addr,
    output logic [DATA_W-1:0]            iomem_wdata,
    input  logic [DATA_W-1:0]            iomem_rdata,
    output logic [$clog2(NUM_CH)-1:0]    grant_o,
    output logic                         err_o
);

    localparam int unsigned GW = $clog2(NUM_CH);
    localparam int unsigned SW = DATA_W / 8;

    if (NUM_CH < 2 || NUM_CH > 8 || (DATA_W % 32) != 0 || TIMEOUT_CYC < 2) begin : g_param_chk
        $error("anabellek_hakem_n: unsupported parameter set");
    end

    typedef enum logic [1:0] {BOSTA, ISTEK, CEVAP} state_e;

    state_e              state_q, state_d;
    logic [GW-1:0]       last_g_q, last_g_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic                iomem_valid_q, iomem_valid_d;
    logic [SW-1:0]       wstrb_q, wstrb_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [NUM_CH-1:0]   ch_ready_q, ch_ready_d;

`ifdef ANABELLEK_ZAMANASIMI_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    logic                win_found;
    logic [GW-1:0]       win_idx;
    logic [31:0]         cand;
    logic [SW-1:0]       sel_wstrb;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    // Round-robin search starting just after the last served channel.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            cand = (32'(last_g_q) + i) % NUM_CH;
            if (!win_found && ch_valid_i[cand[GW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[GW-1:0];
            end
        end
    end

    always_comb begin
        sel_wstrb = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (win_idx == GW'(c)) begin
                sel_wstrb = ch_wstrb_i[c*SW +: SW];
                sel_addr  = ch_addr_i[c*ADDR_W +: ADDR_W];
                sel_wdata = ch_wdata_i[c*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        last_g_d      = last_g_q;
        grant_d       = grant_q;
        iomem_valid_d = iomem_valid_q;
        wstrb_d       = wstrb_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        ch_ready_d    = '0;
`ifdef ANABELLEK_ZAMANASIMI_EN
        cnt_d         = cnt_q;
        err_d         = err_q;
`endif
        case (state_q)
            BOSTA: begin
                if (win_found) begin
                    grant_d       = win_idx;
                    wstrb_d       = sel_wstrb;
                    addr_d        = sel_addr;
                    wdata_d       = sel_wdata;
                    iomem_valid_d = 1'b1;
                    state_d       = ISTEK;
`ifdef ANABELLEK_ZAMANASIMI_EN
                    cnt_d         = '0;
`endif
                end
            end
            ISTEK: begin
                if (iomem_ready) begin
                    rdata_d       = iomem_rdata;
                    iomem_valid_d = 1'b0;
                    ch_ready_d    = NUM_CH'(1) << grant_q;
                    state_d       = CEVAP;
                end
`ifdef ANABELLEK_ZAMANASIMI_EN
                // A ready on the expiry cycle takes priority over the timeout.
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    rdata_d       = {DATA_W/32{32'hDEAD_BEEF}};
                    iomem_valid_d = 1'b0;
                    ch_ready_d    = NUM_CH'(1) << grant_q;
                    err_d         = 1'b1;
                    state_d       = CEVAP;
                end else begin
                    cnt_d         = cnt_q + CNT_W'(1);
                end
`endif
            end
            CEVAP: begin
                last_g_d = grant_q;
                state_d  = BOSTA;
            end
            default: state_d = BOSTA;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= BOSTA;
            last_g_q      <= GW'(NUM_CH - 1);
            grant_q       <= '0;
            iomem_valid_q <= 1'b0;
            wstrb_q       <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            ch_ready_q    <= '0;
`ifdef ANABELLEK_ZAMANASIMI_EN
            cnt_q         <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            last_g_q      <= last_g_d;
            grant_q       <= grant_d;
            iomem_valid_q <= iomem_valid_d;
            wstrb_q       <= wstrb_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            ch_ready_q    <= ch_ready_d;
`ifdef ANABELLEK_ZAMANASIMI_EN
            cnt_q         <= cnt_d;
            err_q         <= err_d;
`endif
        end
    end

    assign ch_ready_o  = ch_ready_q;
    assign ch_rdata_o  = rdata_q;
    assign iomem_valid = iomem_valid_q;
    assign iomem_wstrb = wstrb_q;
    assign iomem_addr  = addr_q;
    assign iomem_wdata = wdata_q;
    assign grant_o     = grant_q;
`ifdef ANABELLEK_ZAMANASIMI_EN
    assign err_o       = err_q;
`else
    assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_anabellek_hakem_n.sv
// Directed bench for anabellek_hakem_n (3 channels, 32-bit bus, timeout of 8 cycles when enabled).
module tb_anabellek_hakem_n;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [2:0]  ch_valid_i;
    logic [11:0] ch_wstrb_i;
    logic [95:0] ch_addr_i;
    logic [95:0] ch_wdata_i;
    logic [2:0]  ch_ready_o;
    logic [31:0] ch_rdata_o;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic [1:0]  grant_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    anabellek_hakem_n #(
        .NUM_CH(3), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ch_valid_i(ch_valid_i), .ch_wstrb_i(ch_wstrb_i),
        .ch_addr_i(ch_addr_i), .ch_wdata_i(ch_wdata_i),
        .ch_ready_o(ch_ready_o), .ch_rdata_o(ch_rdata_o),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .grant_o(grant_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int c, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
        ch_wstrb_i[c*4 +: 4]  = s;
        ch_addr_i[c*32 +: 32] = a;
        ch_wdata_i[c*32 +: 32] = d;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(ch_ready_o), 64'h0);
        chk({tag, "_rdata"}, 64'(ch_rdata_o), 64'h0);
        chk({tag, "_ivalid"}, 64'(iomem_valid), 64'h0);
        chk({tag, "_wstrb"}, 64'(iomem_wstrb), 64'h0);
        chk({tag, "_addr"}, 64'(iomem_addr), 64'h0);
        chk({tag, "_wdata"}, 64'(iomem_wdata), 64'h0);
        chk({tag, "_grant"}, 64'(grant_o), 64'h0);
        chk({tag, "_err"}, 64'(err_o), 64'h0);
    endtask

    // One complete transfer: wait for grant, hold ready off for wait_cyc cycles, then complete.
    task automatic do_xfer(input string tag, input int g, input logic [3:0] s, input logic [31:0] a,
                           input logic [31:0] d, input int wait_cyc, input logic [31:0] rd,
                           input logic [2:0] clr);
        int n;
        logic [2:0] exp_rdy;
        n = 0;
        while (!iomem_valid && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_ivalid"}, 64'(iomem_valid), 64'h1);
        chk({tag, "_grant"}, 64'(grant_o), 64'(g));
        chk({tag, "_addr"}, 64'(iomem_addr), 64'(a));
        chk({tag, "_wstrb"}, 64'(iomem_wstrb), 64'(s));
        chk({tag, "_wdata"}, 64'(iomem_wdata), 64'(d));
        for (int i = 0; i < wait_cyc; i++) begin
            tick();
            chk({tag, "_hold_valid"}, 64'(iomem_valid), 64'h1);
            chk({tag, "_hold_bus"}, {iomem_wstrb, iomem_addr, iomem_wdata[27:0]}, {s, a, d[27:0]});
            chk({tag, "_no_ready"}, 64'(ch_ready_o), 64'h0);
        end
        iomem_ready = 1'b1;
        iomem_rdata = rd;
        tick();
        iomem_ready = 1'b0;
        iomem_rdata = 32'h0;
        exp_rdy = 3'b001 << g;
        chk({tag, "_ready"}, 64'(ch_ready_o), 64'(exp_rdy));
        chk({tag, "_rdata"}, 64'(ch_rdata_o), 64'(rd));
        chk({tag, "_ivalid_off"}, 64'(iomem_valid), 64'h0);
        ch_valid_i = ch_valid_i & ~clr;
        tick();
        chk({tag, "_ready_off"}, 64'(ch_ready_o), 64'h0);
        chk({tag, "_rdata_keep"}, 64'(ch_rdata_o), 64'(rd));
    endtask

    initial begin
        rst_ni      = 1'b0;
        ch_valid_i  = '0;
        ch_wstrb_i  = '0;
        ch_addr_i   = '0;
        ch_wdata_i  = '0;
        iomem_ready = 1'b0;
        iomem_rdata = '0;
        set_ch(0, 4'b0000, 32'h1000_0000, 32'h0000_0000);
        set_ch(1, 4'b0000, 32'h4000_0010, 32'h0000_0000);
        set_ch(2, 4'b0011, 32'h2000_0020, 32'hAABB_CCDD);
        tick();
        tick();
        chk_all_zero("rst");

        // Reset asserted mid-transfer, then channel 0 wins first.
        rst_ni = 1'b1;
        tick();
        ch_valid_i = 3'b111;
        tick();
        chk("rst_pre_ivalid", 64'(iomem_valid), 64'h1);
        chk("rst_pre_grant", 64'(grant_o), 64'h0);
        #2 rst_ni = 1'b0;
        #1;
        chk_all_zero("rst_async");
        tick();
        rst_ni = 1'b1;
        do_xfer("first_ch0", 0, 4'b0000, 32'h1000_0000, 32'h0, 0, 32'h0BAD_F00D, 3'b111);

        // Single read on channel 1, ready four cycles after the request appears.
        ch_valid_i = 3'b010;
        do_xfer("read_ch1", 1, 4'b0000, 32'h4000_0010, 32'h0, 3, 32'h1234_5678, 3'b010);

        // Write on channel 2 with partial strobes.
        ch_valid_i = 3'b100;
        do_xfer("write_ch2", 2, 4'b0011, 32'h2000_0020, 32'hAABB_CCDD, 2, 32'h5555_AAAA, 3'b100);

        // All three channels held valid: strict rotation 0,1,2,0,1,2.
        set_ch(0, 4'b0001, 32'h0000_0100, 32'h0101_0101);
        set_ch(1, 4'b0010, 32'h0000_0200, 32'h0202_0202);
        set_ch(2, 4'b1100, 32'h0000_0300, 32'h0303_0303);
        ch_valid_i = 3'b111;
        for (int r = 0; r < 6; r++) begin
            int g;
            g = r % 3;
            do_xfer("rr", g, 4'(ch_wstrb_i[g*4 +: 4]), 32'h100 * (g + 1), 32'h0101_0101 * (g + 1),
                    r % 2, 32'hC0DE_0000 + 32'(r), (r == 5) ? 3'b111 : 3'b000);
        end

        // Stray ready while idle, then requester drops valid mid-transfer.
        iomem_ready = 1'b1;
        iomem_rdata = 32'hFFFF_FFFF;
        tick();
        tick();
        iomem_ready = 1'b0;
        iomem_rdata = 32'h0;
        chk("stray_ready", 64'(ch_ready_o), 64'h0);
        chk("stray_ivalid", 64'(iomem_valid), 64'h0);
        chk("stray_rdata", 64'(ch_rdata_o), 64'hC0DE_0005);
        ch_valid_i = 3'b001;
        tick();
        tick();
        chk("drop_ivalid", 64'(iomem_valid), 64'h1);
        chk("drop_grant", 64'(grant_o), 64'h0);
        ch_valid_i = 3'b000;
        do_xfer("drop", 0, 4'b0001, 32'h0000_0100, 32'h0101_0101, 2, 32'h7777_0001, 3'b000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("drop_idle_ivalid", 64'(iomem_valid), 64'h0);
            chk("drop_idle_ready", 64'(ch_ready_o), 64'h0);
        end

        // Missing ready: watchdog completes with a poison word, or the transfer simply waits.
        ch_valid_i = 3'b010;
        tick();
        tick();
        chk("to_ivalid", 64'(iomem_valid), 64'h1);
        chk("to_grant", 64'(grant_o), 64'h1);
`ifdef ANABELLEK_ZAMANASIMI_EN
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to_wait_ready", 64'(ch_ready_o), 64'h0);
            chk("to_wait_err", 64'(err_o), 64'h0);
        end
        tick();
        chk("to_ready", 64'(ch_ready_o), 64'h2);
        chk("to_rdata", 64'(ch_rdata_o), 64'hDEAD_BEEF);
        chk("to_err", 64'(err_o), 64'h1);
        chk("to_ivalid_off", 64'(iomem_valid), 64'h0);
        ch_valid_i = 3'b000;
        tick();
        tick();
        chk("to_err_sticky", 64'(err_o), 64'h1);
`else
        for (int i = 0; i < 20; i++) tick();
        chk("nto_ivalid", 64'(iomem_valid), 64'h1);
        chk("nto_ready", 64'(ch_ready_o), 64'h0);
        chk("nto_err", 64'(err_o), 64'h0);
        ch_valid_i = 3'b000;
`endif
        #2 rst_ni = 1'b0;
        #1;
        chk_all_zero("final_rst");
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
